// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receive FIFO depth and the
// receive capture-stage state encoding.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_RXFIFO_DEPTH = 16;

  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_PEND = 1'b1
  } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host bundle of the UART receive FIFO. The master drives the
// receiver frame strobe, consumer handshake and control pulses; the slave is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH = uart_pkg::UART_RXFIFO_DEPTH
) ();
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic                   RxDone;
  logic [UART_DATA_W-1:0] RxData;
  logic [UART_DATA_W-1:0] DataOut;
  logic                   DataValid;
  logic                   DataReady;
  logic [AW:0]            Count;
  logic                   Full;
  logic                   Overrun;
  logic                   OvrClr;
  logic                   Flush;

  modport master (
    output RxDone, RxData, DataReady, OvrClr, Flush,
    input  DataOut, DataValid, Count, Full, Overrun
  );

  modport slave (
    input  RxDone, RxData, DataReady, OvrClr, Flush,
    output DataOut, DataValid, Count, Full, Overrun
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port, deliberately without reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RXFIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side show-ahead FIFO: one capture per RxDone rising edge, a single
// pending stage, then a push into the array; host drains with valid/ready.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RXFIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           Clk,
  input  logic           Rst,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  cap_state_e             cap_state_r;
  cap_state_e             cap_state_s;
  logic                   rx_done_d_r;
  logic [UART_DATA_W-1:0] cap_byte_r;
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            count_r;
  logic                   overrun_r;
  logic [UART_DATA_W-1:0] rd_data_s;

  logic capture_s;
  logic cap_pend_s;
  logic full_s;
  logic valid_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Event detect and push/pop/drop qualification; Flush suppresses all of them
  always_comb begin
    capture_s  = bus.RxDone & ~rx_done_d_r;
    cap_pend_s = (cap_state_r == CAP_PEND);
    full_s     = (count_r == FULL_CNT);
    valid_s    = (count_r != '0);
    pop_s      = valid_s & bus.DataReady & ~bus.Flush;
    push_s     = cap_pend_s & ~bus.Flush & (~full_s | pop_s);
    drop_s     = cap_pend_s & ~bus.Flush & full_s & ~pop_s;
  end

  // Capture sequencer next state
  always_comb begin
    cap_state_s = cap_state_r;
    case (cap_state_r)
      CAP_IDLE: begin
        if (capture_s && !bus.Flush) begin
          cap_state_s = CAP_PEND;
        end else begin
          cap_state_s = CAP_IDLE;
        end
      end
      CAP_PEND: cap_state_s = CAP_IDLE;
      default:  cap_state_s = CAP_IDLE;
    endcase
  end

  // Capture sequencer state and RxDone delay; delay resets high to ignore a held level
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cap_state_r <= CAP_IDLE;
      rx_done_d_r <= 1'b1;
    end else begin
      cap_state_r <= cap_state_s;
      rx_done_d_r <= bus.RxDone;
    end
  end

  // Captured byte holding register, data path only
  always_ff @(posedge Clk) begin
    if (capture_s) begin
      cap_byte_r <= bus.RxData;
    end
  end

  // Pointers and occupancy; Count is what tells full from empty when pointers match
  always_ff @(posedge Clk) begin
    if (Rst || bus.Flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overrun: a drop wins over a coincident clear
  always_ff @(posedge Clk) begin
    if (Rst) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (bus.OvrClr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (Clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (cap_byte_r),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  assign bus.DataOut   = rd_data_s;
  assign bus.DataValid = valid_s;
  assign bus.Count     = count_r;
  assign bus.Full      = full_s;
  assign bus.Overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a fill/overrun vector table plus
// hand-written sequences for latency, full-boundary, flush, wrap and reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RxDone rises now; the byte is in the FIFO after the second edge
  task automatic rise(input logic [7:0] d);
    bus.RxData = d;
    bus.RxDone = 1'b1;
    tick();
    tick();
  endtask

  task automatic fall();
    bus.RxDone = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst           = 1'b1;
    bus.RxDone    = 1'b0;
    bus.RxData    = 8'h00;
    bus.DataReady = 1'b0;
    bus.OvrClr    = 1'b0;
    bus.Flush     = 1'b0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].data      = 8'(i);
      vecs[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
      vecs[i].exp_full  = (i >= 15);
      vecs[i].exp_ovr   = (i == 16);
    end

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_count", 32'(bus.Count), 32'd0);
    chk("reset_valid", 32'(bus.DataValid), 32'd0);
    chk("reset_full", 32'(bus.Full), 32'd0);
    chk("reset_ovr", 32'(bus.Overrun), 32'd0);

    // Single long frame: exactly one push, two-cycle latency
    bus.RxData = 8'hA5;
    bus.RxDone = 1'b1;
    tick();
    chk("single_latency_count", 32'(bus.Count), 32'd0);
    tick();
    chk("single_valid", 32'(bus.DataValid), 32'd1);
    chk("single_dout", 32'(bus.DataOut), 32'hA5);
    chk("single_count", 32'(bus.Count), 32'd1);
    for (int i = 0; i < 38; i++) tick();
    fall();
    tick();
    chk("single_long_count", 32'(bus.Count), 32'd1);
    bus.DataReady = 1'b1;
    tick();
    bus.DataReady = 1'b0;
    chk("single_pop_count", 32'(bus.Count), 32'd0);
    chk("single_pop_valid", 32'(bus.DataValid), 32'd0);

    // Fill and overrun from the vector table
    for (int i = 0; i < 17; i++) begin
      rise(vecs[i].data);
      chk($sformatf("fill%0d_count", i), 32'(bus.Count), 32'(vecs[i].exp_count));
      chk($sformatf("fill%0d_full", i), 32'(bus.Full), 32'(vecs[i].exp_full));
      chk($sformatf("fill%0d_ovr", i), 32'(bus.Overrun), 32'(vecs[i].exp_ovr));
      chk($sformatf("fill%0d_head", i), 32'(bus.DataOut), 32'h00);
      fall();
    end
    bus.DataReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_dout", i), 32'(bus.DataOut), 32'(i));
      tick();
    end
    bus.DataReady = 1'b0;
    chk("drain_empty", 32'(bus.DataValid), 32'd0);
    bus.OvrClr = 1'b1;
    tick();
    bus.OvrClr = 1'b0;
    chk("ovrclr_first", 32'(bus.Overrun), 32'd0);

    // Push and pop on the same edge while full
    for (int i = 0; i < 16; i++) begin
      rise(8'(8'h20 + i));
      fall();
    end
    chk("refill_count", 32'(bus.Count), 32'd16);
    bus.RxData = 8'h77;
    bus.RxDone = 1'b1;
    tick();
    bus.DataReady = 1'b1;
    tick();
    bus.DataReady = 1'b0;
    chk("fullpp_count", 32'(bus.Count), 32'd16);
    chk("fullpp_ovr", 32'(bus.Overrun), 32'd0);
    chk("fullpp_head", 32'(bus.DataOut), 32'h21);
    fall();

    // Drop coincident with OvrClr keeps Overrun set
    bus.RxData = 8'h88;
    bus.RxDone = 1'b1;
    tick();
    bus.OvrClr = 1'b1;
    tick();
    bus.OvrClr = 1'b0;
    chk("coinc_ovr", 32'(bus.Overrun), 32'd1);
    chk("coinc_count", 32'(bus.Count), 32'd16);
    fall();
    bus.DataReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain2_%0d", i), 32'(bus.DataOut), (i < 15) ? 32'(8'h21 + i) : 32'h77);
      tick();
    end
    bus.DataReady = 1'b0;
    chk("drain2_empty", 32'(bus.DataValid), 32'd0);

    // Flush with a capture pending
    for (int i = 1; i <= 3; i++) begin
      rise(8'(i));
      fall();
    end
    chk("preflush_count", 32'(bus.Count), 32'd3);
    bus.RxData = 8'h99;
    bus.RxDone = 1'b1;
    tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    chk("flush_count", 32'(bus.Count), 32'd0);
    chk("flush_valid", 32'(bus.DataValid), 32'd0);
    tick();
    chk("flush_no_late_push", 32'(bus.Count), 32'd0);
    chk("flush_keeps_ovr", 32'(bus.Overrun), 32'd1);
    fall();
    bus.OvrClr = 1'b1;
    tick();
    bus.OvrClr = 1'b0;
    chk("ovrclr_alone", 32'(bus.Overrun), 32'd0);
    rise(8'h5A);
    chk("postflush_dout", 32'(bus.DataOut), 32'h5A);
    chk("postflush_count", 32'(bus.Count), 32'd1);
    fall();
    bus.DataReady = 1'b1;
    tick();
    bus.DataReady = 1'b0;

    // Wrap-around: each byte popped one cycle after it becomes valid
    for (int i = 0; i < 40; i++) begin
      rise(8'(i));
      chk($sformatf("wrap%0d_dout", i), 32'(bus.DataOut), 32'(i));
      chk($sformatf("wrap%0d_count", i), 32'(bus.Count), 32'd1);
      bus.DataReady = 1'b1;
      tick();
      bus.DataReady = 1'b0;
      chk($sformatf("wrap%0d_popped", i), 32'(bus.Count), 32'd0);
      fall();
    end
    chk("wrap_ovr", 32'(bus.Overrun), 32'd0);

    // Reset with a capture pending and RxDone held high across release
    rise(8'h11);
    fall();
    bus.RxData = 8'h33;
    bus.RxDone = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_valid", 32'(bus.DataValid), 32'd0);
    fall();
    rise(8'h44);
    chk("postrst_dout", 32'(bus.DataOut), 32'h44);
    chk("postrst_count", 32'(bus.Count), 32'd1);
    fall();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
